change_dispense_ctrl: RTL and testbench
=======================================

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 Parameter GAP_CYC, default 16: idle cycles enforced between consecutive hopper ejections.
REQ-002 Parameter TIMEOUT_CYC, default 1000000: max cycles hop_req may wait for hop_ack.
REQ-003 clk  input  1  system clock, 100 MHz, all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; request to dispense amount.
REQ-006 amount  input  12  change owed in cents, unsigned, sampled only when start accepted.
REQ-007 abort  input  1  level; cancel an in-progress dispense.
REQ-008 hop_empty  input  4  per-hopper empty flags; bit3=50c, bit2=25c, bit1=10c, bit0=5c.
REQ-009 hop_ack  input  1  one-cycle pulse from hopper: one coin ejected.
REQ-010 hop_req  output  1  level; eject one coin from hopper hop_sel.
REQ-011 hop_sel  output  2  hopper index: 3=50c, 2=25c, 1=10c, 0=5c.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at the end of every accepted request (success, fault or abort).
REQ-014 err_short  output  1  sticky: change could not be completed with available coins.
REQ-015 err_timeout  output  1  sticky: hopper failed to acknowledge.
REQ-016 remaining  output  12  cents still owed; registered.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, REQ, GAP, FIN, all outputs registered.
REQ-018 IDLE: start accepted only in IDLE; start while busy SHALL be ignored.
REQ-019 On accepted start: remaining<=amount, err_short<=0, err_timeout<=0, next state SELECT.
REQ-020 SELECT (one cycle): if remaining==0 -> FIN; else pick largest denomination d in {50,25,10,5} with hop_empty bit clear and d<=remaining -> load hop_sel, go REQ; if none qualifies -> err_short<=1, go FIN.
REQ-021 hop_empty SHALL be sampled only in SELECT; changes during REQ/GAP take effect at next SELECT.
REQ-022 REQ: hop_req=1 and hop_sel stable for every REQ cycle; hop_req=0 in all other states.
REQ-023 hop_ack in REQ: remaining<=remaining-d, hop_req deasserts next cycle, go GAP; hop_ack outside REQ SHALL be ignored.
REQ-024 Subtraction SHALL never underflow (guaranteed by d<=remaining in SELECT).
REQ-025 REQ wait counter SHALL reset on entry; if it reaches TIMEOUT_CYC without hop_ack -> err_timeout<=1, go FIN, remaining unchanged.
REQ-026 GAP: count exactly GAP_CYC cycles, then SELECT.
REQ-027 Latency: start accepted at edge N -> SELECT at N+1 -> hop_req high from edge N+2.
REQ-028 FIN: done=1 for exactly one cycle, next state IDLE; err flags and remaining held until next accepted start.
REQ-029 start with amount==0: SELECT -> FIN, done pulse 3 cycles after start, no hop_req.
REQ-030 amount not a multiple of 5: dispense greedily to residual 1-4 c, then err_short per REQ-020.
REQ-031 abort in SELECT or GAP -> FIN next cycle; abort in REQ without hop_ack -> FIN; abort and hop_ack same REQ cycle -> coin counted, then FIN; abort in IDLE ignored.
REQ-032 Abort SHALL not set either error flag; remaining shows uncollected change.

Reset
REQ-033 rst low SHALL asynchronously force IDLE, hop_req=0, hop_sel=0, busy=0, done=0, err_short=0, err_timeout=0, remaining=0, counters=0, including mid-dispense.
REQ-034 Release of rst SHALL not generate hop_req or done; first action requires a new start.

Verification
REQ-035 All hoppers full, start amount=90, GAP_CYC=4, ack 2 cycles after each req -> sel sequence 3,2,1,0 (50+25+10+5); remaining 40,15,5,0; one done, no errors.
REQ-036 hop_empty=4'b1000, amount=100 -> four ejections from sel 2 (25c); remaining 0; done, no errors.
REQ-037 hop_empty=4'b0011, amount=30 -> one 25c ejection, remaining=5, err_short=1, done pulse.
REQ-038 TIMEOUT_CYC=8, amount=10, hop_ack never asserted -> hop_req high exactly 8 cycles, err_timeout=1, remaining=10, done.
REQ-039 amount=75, abort asserted in the same cycle as the first hop_ack -> remaining=25, FIN, no errors; second start during busy ignored.
REQ-040 rst low during GAP of amount=60 dispense -> all outputs zero immediately; after release, start amount=0 -> done 3 cycles later, no hop_req.

Source files
------------

// File: rtl/change_dispense_ctrl.sv
// Coin-change dispense controller: greedily ejects 50/25/10/5c coins from four hoppers
// until the owed amount is paid, with inter-coin spacing, ack timeout and abort handling.
module change_dispense_ctrl #(
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] amount,
    input  logic        abort,
    input  logic [3:0]  hop_empty,
    input  logic        hop_ack,
    output logic        hop_req,
    output logic [1:0]  hop_sel,
    output logic        busy,
    output logic        done,
    output logic        err_short,
    output logic        err_timeout,
    output logic [11:0] remaining
);

    localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        REQ,
        GAP,
        FIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pick_ok;
    logic [1:0]    pick_sel;

    function automatic logic [11:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'd3:    return 12'd50;
            2'd2:    return 12'd25;
            2'd1:    return 12'd10;
            default: return 12'd5;
        endcase
    endfunction

    // Largest stocked denomination that still fits into the amount owed.
    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        pick_ok  = 1'b0;
        pick_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!pick_ok && !hop_empty[i] && coin_value(2'(i)) <= remaining) begin
                pick_ok  = 1'b1;
                pick_sel = 2'(i);
            end
        end
    end

    // NOTE: non-blocking assignments only, so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hop_req     <= 1'b0;
            hop_sel     <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_short   <= 1'b0;
            err_timeout <= 1'b0;
            remaining   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining   <= amount;
                        err_short   <= 1'b0;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (abort || remaining == '0) begin
                        state <= FIN;
                    end else if (pick_ok) begin
                        hop_sel <= pick_sel;
                        hop_req <= 1'b1;
                        cnt     <= '0;
                        state   <= REQ;
                    end else begin
                        err_short <= 1'b1;
                        state     <= FIN;
                    end
                end
                REQ: begin
                    // An ack always counts the coin, even when abort arrives with it.
                    if (hop_ack) begin
                        remaining <= remaining - coin_value(hop_sel);
                        hop_req   <= 1'b0;
                        cnt       <= '0;
                        state     <= abort ? FIN : GAP;
                    end else if (abort) begin
                        hop_req <= 1'b0;
                        state   <= FIN;
                    end else if (cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        hop_req     <= 1'b0;
                        state       <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= FIN;
                    end else if (cnt == GAP_LAST) begin
                        state <= SELECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Self-checking bench for change_dispense_ctrl: directed scenarios plus randomized
// transactions scored against a greedy coin-change model and a hopper responder.
module tb_change_dispense_ctrl;

    localparam int GAP = 4;
    localparam int TO  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] amount = '0;
    logic        abort = 1'b0;
    logic [3:0]  hop_empty = '0;
    logic        hop_ack = 1'b0;
    logic        hop_req;
    logic [1:0]  hop_sel;
    logic        busy;
    logic        done;
    logic        err_short;
    logic        err_timeout;
    logic [11:0] remaining;

    int n_checks = 0;
    int n_fail   = 0;

    int ack_dly = 1;
    bit ack_en = 1'b1;
    bit abort_first = 1'b0;
    int req_age = 0;
    int req_cycles = 0;
    int low_len = 0;
    int done_cnt = 0;
    bit seen_req = 1'b0;
    bit prev_req = 1'b0;
    bit rec_pending = 1'b0;
    int ejected[$];
    int trail[$];
    int exp_sel[$];
    int exp_trail[$];
    bit exp_short;

    change_dispense_ctrl #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .amount     (amount),
        .abort      (abort),
        .hop_empty  (hop_empty),
        .hop_ack    (hop_ack),
        .hop_req    (hop_req),
        .hop_sel    (hop_sel),
        .busy       (busy),
        .done       (done),
        .err_short  (err_short),
        .err_timeout(err_timeout),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Greedy change-making over stocked coins, independent of any timing.
    task automatic model(input int amt, input logic [3:0] empty);
        int coin[4] = '{5, 10, 25, 50};
        int rem;
        bit found;
        exp_sel.delete();
        exp_trail.delete();
        exp_short = 1'b0;
        rem = amt;
        while (rem > 0) begin
            found = 1'b0;
            for (int i = 3; i >= 0; i--) begin
                if (!found && !empty[i] && coin[i] <= rem) begin
                    found = 1'b1;
                    rem -= coin[i];
                    exp_sel.push_back(i);
                    exp_trail.push_back(rem);
                end
            end
            if (!found) begin
                exp_short = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_mon();
        ejected.delete();
        trail.delete();
        req_cycles  = 0;
        done_cnt    = 0;
        seen_req    = 1'b0;
        low_len     = 0;
        rec_pending = 1'b0;
    endtask

    // Hopper responder and monitor, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            hop_ack = 1'b0;
            if (rec_pending) begin
                trail.push_back(int'(remaining));
                rec_pending = 1'b0;
            end
            if (done) done_cnt++;
            if (hop_req) begin
                req_cycles++;
                if (!prev_req && seen_req) check("gap_len", low_len, GAP + 1);
                seen_req = 1'b1;
                low_len  = 0;
                if (ack_en) begin
                    if (req_age == ack_dly) begin
                        hop_ack = 1'b1;
                        if (abort_first && ejected.size() == 0) abort = 1'b1;
                        ejected.push_back(int'(hop_sel));
                        rec_pending = 1'b1;
                        req_age = 0;
                    end else begin
                        req_age++;
                    end
                end
            end else begin
                req_age = 0;
                low_len++;
            end
            prev_req = hop_req;
        end
    end

    task automatic run_txn(input string tag, input int amt, input logic [3:0] empty, input int dly,
                           input bit ack_on, input bit abort_on, input bit busy_start);
        int  k;
        int  exp_rem;
        bit  first_req;
        bit  exp_to;
        bit  got_done;
        model(amt, empty);
        first_req = exp_sel.size() > 0;
        exp_to = 1'b0;
        if (!ack_on && first_req) begin
            exp_to = 1'b1;
            exp_short = 1'b0;
            exp_sel.delete();
            exp_trail.delete();
        end
        if (abort_on && first_req) begin
            while (exp_sel.size() > 1) begin
                void'(exp_sel.pop_back());
                void'(exp_trail.pop_back());
            end
            exp_short = 1'b0;
        end
        exp_rem = (exp_trail.size() > 0) ? exp_trail[exp_trail.size() - 1] : amt;

        hop_empty   = empty;
        ack_dly     = dly;
        ack_en      = ack_on;
        abort_first = abort_on;
        clear_mon();
        amount = amt[11:0];
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        amount = 12'($urandom);
        k = 1;
        check({tag, "_busy_k1"}, busy, 1);
        check({tag, "_req_k1"}, hop_req, 0);
        @(negedge clk);
        k = 2;
        check({tag, "_req_k2"}, hop_req, int'(first_req));
        got_done = 1'b0;
        while (!got_done && k < 20000) begin
            @(negedge clk);
            k++;
            if (busy_start && k == 3) begin
                start  = 1'b1;
                amount = 12'd5;
            end else begin
                start = 1'b0;
            end
            if (done) got_done = 1'b1;
        end
        check({tag, "_done_seen"}, int'(got_done), 1);
        check({tag, "_busy_at_done"}, busy, 0);
        if (amt == 0) check({tag, "_done_lat"}, k, 3);
        abort = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_remaining"}, remaining, exp_rem);
        check({tag, "_err_short"}, err_short, int'(exp_short));
        check({tag, "_err_timeout"}, err_timeout, int'(exp_to));
        if (exp_to) check({tag, "_req_cycles"}, req_cycles, TO);
        check({tag, "_n_coins"}, ejected.size(), exp_sel.size());
        for (int i = 0; i < exp_sel.size() && i < ejected.size(); i++) begin
            check({tag, "_sel"}, ejected[i], exp_sel[i]);
            if (i < trail.size()) check({tag, "_trail"}, trail[i], exp_trail[i]);
        end
    endtask

    task automatic reset_mid_gap();
        int k;
        clear_mon();
        hop_empty   = 4'b0000;
        ack_dly     = 0;
        ack_en      = 1'b1;
        abort_first = 1'b0;
        amount = 12'd60;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (ejected.size() == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rst_first_ack", ejected.size(), 1);
        @(negedge clk);
        check("rst_gap_remaining", remaining, 10);
        check("rst_gap_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async_req", hop_req, 0);
        check("rst_async_sel", hop_sel, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        check("rst_async_short", err_short, 0);
        check("rst_async_to", err_timeout, 0);
        check("rst_async_rem", remaining, 0);
        clear_mon();
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_release_req", req_cycles, 0);
        check("rst_release_done", done_cnt, 0);
        check("rst_release_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_req", hop_req, 0);
        check("reset_sel", hop_sel, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_short", err_short, 0);
        check("reset_timeout", err_timeout, 0);
        check("reset_rem", remaining, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("release_req", hop_req, 0);
        check("release_done", done, 0);

        run_txn("full90", 90, 4'b0000, 1, 1'b1, 1'b0, 1'b0);
        run_txn("no50_100", 100, 4'b1000, 2, 1'b1, 1'b0, 1'b0);
        run_txn("short30", 30, 4'b0011, 0, 1'b1, 1'b0, 1'b0);
        run_txn("timeout10", 10, 4'b0000, 0, 1'b0, 1'b0, 1'b0);
        run_txn("abort75", 75, 4'b0000, 1, 1'b1, 1'b1, 1'b1);
        run_txn("odd83", 83, 4'b0000, 3, 1'b1, 1'b0, 1'b0);
        run_txn("tiny3", 3, 4'b0000, 0, 1'b1, 1'b0, 1'b0);
        reset_mid_gap();
        run_txn("zero_after_rst", 0, 4'b0000, 0, 1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            run_txn("rand", int'($urandom_range(0, 300)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 5)), 1'b1, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
